pe_spad_ctrl: RTL and testbench
===============================

// Module: pe_spad_ctrl
// PURPOSE
//  Sequencer for one PE scratchpad (1 write port, 2 combinational read ports) running the 1-D conv row primitive.
//  Accepts a job config, streams S filter weights then W ifmap values into the spad, then issues tap-by-tap read-address
//  pairs plus MAC control for each of the W-S+1 output windows. Hands each finished psum off with a valid/ready handshake.
//  Sits between the PE input FIFO/NoC port and the spad + MAC datapath.
// PARAMETERS
//  dataSize     8   width of the spad data word / in_data
//  numRegister  16  spad depth; AW=$clog2(numRegister), LW=AW+1
// PORTS
//  clk             in   1         clock; all state updates on posedge
//  rst             in   1         asynchronous, active-high reset
//  cfg_valid       in   1         job config offered
//  cfg_ready       out  1         controller can accept a config (IDLE only)
//  cfg_filt_len    in   LW        S = number of filter taps
//  cfg_ifmap_len   in   LW        W = number of ifmap values in the row
//  cfg_err         out  1         1-cycle pulse: accepted config was illegal
//  in_valid        in   1         load-stream word valid
//  in_ready        out  1         load-stream word accepted (LOAD only)
//  in_data         in   dataSize  load-stream word (weights first, then ifmap)
//  spad_wr_en      out  1         spad write strobe
//  spad_wr_addr    out  AW        spad write address
//  spad_wr_data    out  dataSize  = in_data (combinational pass-through)
//  spad_rd_addr_1  out  AW        weight read address
//  spad_rd_addr_2  out  AW        ifmap read address
//  mac_en          out  1         MAC consumes rd_data_1*rd_data_2 this cycle
//  mac_first       out  1         first tap of window: MAC loads product instead of accumulating
//  mac_last        out  1         last tap of window
//  psum_valid      out  1         external accumulator holds a finished psum
//  psum_ready      in   1         psum consumer accepts it
//  done            out  1         1-cycle pulse after the last psum handshake
// BEHAVIOUR
//  States IDLE, LOAD, COMPUTE, OUT. Reset -> IDLE; all outputs 0 except cfg_ready=1; all counters 0.
//  IDLE: cfg_ready=1. On cfg_valid, latch S,W. Legal iff S>=1, W>=S, S+W<=numRegister -> LOAD.
//   Illegal: cfg_err=1 next cycle, stay IDLE, nothing written.
//  LOAD: in_ready=1. Each in_valid&in_ready: spad_wr_en=1, spad_wr_addr=wr_ptr, wr_ptr++ (weights at 0..S-1, ifmap at S..S+W-1).
//   The write numbered S+W (count from 1) -> COMPUTE with t=0, o=0. spad_wr_en=0 in every state other than LOAD.
//  COMPUTE: one tap per cycle, no stalls. spad_rd_addr_1=t, spad_rd_addr_2=S+o+t, mac_en=1, mac_first=(t==0), mac_last=(t==S-1).
//   S=1: mac_first=mac_last=1 in the same cycle. After mac_last -> OUT. The psum register updates on that edge.
//  OUT: psum_valid=1; mac_en=0; read addresses 0. Hold until psum_ready.
//   On the handshake, if o==W-S: done=1 next cycle -> IDLE. Otherwise o++, t=0 -> COMPUTE.
//  Read addresses and MAC strobes are 0 outside COMPUTE. Read data is combinational, so the MAC samples in the same cycle it is addressed.
//  Job cycle count with no backpressure: 1 (cfg) + (S+W) (load) + (W-S+1)*(S+1).
//  psum_ready while not in OUT: ignored. in_valid outside LOAD: ignored (in_ready=0). cfg_valid outside IDLE: ignored.
//  rst asserted mid-job: immediate return to IDLE; outputs at reset values; partial spad contents are don't-care.
// TESTING
//  T1 S=3,W=5, load 1,2,3,1,2,3,4,5 with a bench MAC model -> pairs (0,3)(1,4)(2,5) / (0,4)(1,5)(2,6) / (0,5)(1,6)(2,7).
//     Psums 14, 20, 26; done pulses once; 1+8+12 = 21 cycles.
//  T2 same job, in_valid every other cycle and psum_ready low 5 cycles at each OUT -> exactly 8 writes to addr 0..7.
//     psum_valid held, mac_en=0 while stalled; psums unchanged.
//  T3 configs (S=0,W=4), (S=5,W=3), (S=10,W=8) -> cfg_err pulse each time, state IDLE, spad_wr_en never 1.
//  T4 S=8,W=8 (spad full) -> 16 writes, one window, rd_addr_2 runs 8..15. S=1,W=1 -> mac_first=mac_last=1 in one cycle, one psum.
//  T5 rst pulsed on the 2nd COMPUTE cycle of T1 -> same-cycle outputs to reset values, cfg_ready=1.
//     A following T1 job completes with psums 14, 20, 26.

Source files
------------

// File: rtl/pe_spad_ctrl_if.sv
// Bundle of every non-clock signal between the PE scratchpad sequencer and its neighbours:
// the config port, the load stream, the spad/MAC control and the psum handshake.
interface pe_spad_ctrl_if #(
    parameter int dataSize    = 8,
    parameter int numRegister = 16
);
    localparam int AW = $clog2(numRegister);
    localparam int LW = AW + 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [LW-1:0]       cfg_filt_len;
    logic [LW-1:0]       cfg_ifmap_len;
    logic                cfg_err;

    logic                in_valid;
    logic                in_ready;
    logic [dataSize-1:0] in_data;

    logic                spad_wr_en;
    logic [AW-1:0]       spad_wr_addr;
    logic [dataSize-1:0] spad_wr_data;
    logic [AW-1:0]       spad_rd_addr_1;
    logic [AW-1:0]       spad_rd_addr_2;

    logic                mac_en;
    logic                mac_first;
    logic                mac_last;

    logic                psum_valid;
    logic                psum_ready;
    logic                done;

    // Controller side.
    modport slave (
        input  cfg_valid, cfg_filt_len, cfg_ifmap_len, in_valid, in_data, psum_ready,
        output cfg_ready, cfg_err, in_ready,
               spad_wr_en, spad_wr_addr, spad_wr_data, spad_rd_addr_1, spad_rd_addr_2,
               mac_en, mac_first, mac_last, psum_valid, done
    );

    // Environment side: FIFO/NoC port, spad, MAC and psum consumer.
    modport master (
        output cfg_valid, cfg_filt_len, cfg_ifmap_len, in_valid, in_data, psum_ready,
        input  cfg_ready, cfg_err, in_ready,
               spad_wr_en, spad_wr_addr, spad_wr_data, spad_rd_addr_1, spad_rd_addr_2,
               mac_en, mac_first, mac_last, psum_valid, done
    );
endinterface

// File: rtl/pe_spad_ctrl.sv
// PE scratchpad sequencer for the 1-D conv row primitive: loads S weights + W ifmap values,
// then walks every output window tap by tap and hands each psum off over a valid/ready port.
module pe_spad_ctrl #(
    parameter int dataSize    = 8,
    parameter int numRegister = 16
) (
    input  logic              clk,
    input  logic              rst,
    pe_spad_ctrl_if.slave     bus
);
    localparam int AW = $clog2(numRegister);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [LW:0]   MAX_FILL = (LW+1)'(numRegister);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUT
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       s_len_q;
    logic [LW-1:0]       w_len_q;
    logic [LW-1:0]       wr_cnt_q;
    logic [LW-1:0]       tap_q;
    logic [LW-1:0]       win_q;
    logic                cfg_err_q;
    logic                done_q;

    logic [LW:0]         fill;
    logic                cfg_legal;
    logic                load_last;
    logic                tap_last;
    logic                win_last;
    logic [dataSize-1:0] wr_data;

    // Legality is judged on the offered config so an illegal job never leaves IDLE.
    assign fill      = {1'b0, bus.cfg_filt_len} + {1'b0, bus.cfg_ifmap_len};
    assign cfg_legal = (bus.cfg_filt_len != '0)
                    && (bus.cfg_ifmap_len >= bus.cfg_filt_len)
                    && (fill <= MAX_FILL);

    assign load_last = (wr_cnt_q + ONE) == (s_len_q + w_len_q);
    assign tap_last  = (tap_q + ONE) == s_len_q;
    assign win_last  = win_q == (w_len_q - s_len_q);

    assign wr_data          = bus.in_data;
    assign bus.spad_wr_data = wr_data;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output and the next state get a default first so no path infers a latch.
        state_d            = state_q;
        bus.cfg_ready      = 1'b0;
        bus.in_ready       = 1'b0;
        bus.spad_wr_en     = 1'b0;
        bus.spad_wr_addr   = '0;
        bus.spad_rd_addr_1 = '0;
        bus.spad_rd_addr_2 = '0;
        bus.mac_en         = 1'b0;
        bus.mac_first      = 1'b0;
        bus.mac_last       = 1'b0;
        bus.psum_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid && cfg_legal) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.in_ready     = 1'b1;
                bus.spad_wr_addr = AW'(wr_cnt_q);
                if (bus.in_valid) begin
                    bus.spad_wr_en = 1'b1;
                    if (load_last) begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                // Weights live at 0..S-1, ifmap at S..S+W-1; window o starts at ifmap offset o.
                bus.mac_en         = 1'b1;
                bus.spad_rd_addr_1 = AW'(tap_q);
                bus.spad_rd_addr_2 = AW'(s_len_q + win_q + tap_q);
                bus.mac_first      = (tap_q == '0);
                bus.mac_last       = tap_last;
                if (tap_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                bus.psum_valid = 1'b1;
                if (bus.psum_ready) begin
                    state_d = win_last ? IDLE : COMPUTE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_len_q   <= '0;
            w_len_q   <= '0;
            wr_cnt_q  <= '0;
            tap_q     <= '0;
            win_q     <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        s_len_q   <= bus.cfg_filt_len;
                        w_len_q   <= bus.cfg_ifmap_len;
                        wr_cnt_q  <= '0;
                        tap_q     <= '0;
                        win_q     <= '0;
                        cfg_err_q <= !cfg_legal;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        wr_cnt_q <= wr_cnt_q + ONE;
                    end
                end
                COMPUTE: begin
                    tap_q <= tap_last ? '0 : tap_q + ONE;
                end
                OUT: begin
                    if (bus.psum_ready) begin
                        if (win_last) begin
                            done_q <= 1'b1;
                        end else begin
                            win_q <= win_q + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_spad_ctrl.sv
// Self-checking bench for pe_spad_ctrl: a spad array and MAC model sit on the bus, and every
// window's expected psum and address pair is derived from the conv formula over the loaded row.
module tb_pe_spad_ctrl;
    logic clk;
    logic rst;

    pe_spad_ctrl_if #(.dataSize(8), .numRegister(16)) bus ();

    pe_spad_ctrl #(.dataSize(8), .numRegister(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          wr_count;
    int          acc;
    logic [7:0]  spad [16];
    logic [7:0]  job_data [16];

    // Environment: the scratchpad itself and the MAC that consumes its two read ports.
    always @(posedge clk) begin
        if (bus.spad_wr_en) begin
            spad[bus.spad_wr_addr] <= bus.spad_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) acc <= 0;
        else if (bus.mac_en)
            acc <= (bus.mac_first ? 0 : acc)
                 + int'(spad[bus.spad_rd_addr_1]) * int'(spad[bus.spad_rd_addr_2]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // gap_mode: 0 stream every cycle, 1 every other cycle, 2 random plus junk on ignored inputs.
    // abort_at: non-zero pulses rst on that COMPUTE cycle of the job.
    task automatic run_job(input int s, input int w, input int gap_mode, input int stall,
                           input int abort_at);
        bit legal;
        int cyc, idx, guard, cc, wr0, expected;
        bit v;
        legal = (s >= 1) && (w >= s) && (s + w <= 16);
        cyc = 0; idx = 0; guard = 0; cc = 0;

        @(negedge clk);
        bus.cfg_valid     = 1'b1;
        bus.cfg_filt_len  = 5'(s);
        bus.cfg_ifmap_len = 5'(w);
        #1 check("cfg_ready", bus.cfg_ready, 1);
        wr0 = wr_count;
        @(posedge clk); cyc = 1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1 check("cfg_err", bus.cfg_err, legal ? 0 : 1);
        if (!legal) begin
            check("err_stays_idle", bus.cfg_ready, 1);
            @(posedge clk); @(negedge clk); #1;
            check("err_pulse_end", bus.cfg_err, 0);
            check("err_no_writes", wr_count - wr0, 0);
            return;
        end

        while (idx < s + w && guard < 400) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = job_data[idx];
            if (gap_mode == 2) begin
                bus.cfg_valid  = 1'($urandom_range(0, 1));
                bus.psum_ready = 1'($urandom_range(0, 1));
            end
            #1;
            check("load_in_ready", bus.in_ready, 1);
            check("load_cfg_ready", bus.cfg_ready, 0);
            check("load_wr_en", bus.spad_wr_en, v);
            check("load_mac_en", bus.mac_en, 0);
            if (v) begin
                check("load_wr_addr", bus.spad_wr_addr, idx);
                check("load_wr_data", bus.spad_wr_data, job_data[idx]);
            end
            @(posedge clk); cyc++;
            if (v) idx++;
            @(negedge clk); guard++;
        end
        bus.in_valid = 1'b0; bus.cfg_valid = 1'b0; bus.psum_ready = 1'b0;
        if (guard >= 400) check("load_timeout", 0, 1);

        for (int o = 0; o <= w - s; o++) begin
            for (int t = 0; t < s; t++) begin
                cc++;
                if (abort_at != 0 && cc == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check("rst_cfg_ready", bus.cfg_ready, 1);
                    check("rst_mac_en", bus.mac_en, 0);
                    check("rst_mac_first", bus.mac_first, 0);
                    check("rst_mac_last", bus.mac_last, 0);
                    check("rst_rd1", bus.spad_rd_addr_1, 0);
                    check("rst_rd2", bus.spad_rd_addr_2, 0);
                    check("rst_psum_valid", bus.psum_valid, 0);
                    check("rst_in_ready", bus.in_ready, 0);
                    @(posedge clk); @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (gap_mode == 2) begin
                    bus.psum_ready = 1'($urandom_range(0, 1));
                    bus.in_valid   = 1'($urandom_range(0, 1));
                end
                #1;
                check("cmp_mac_en", bus.mac_en, 1);
                check("cmp_rd1", bus.spad_rd_addr_1, t);
                check("cmp_rd2", bus.spad_rd_addr_2, s + o + t);
                check("cmp_first", bus.mac_first, (t == 0) ? 1 : 0);
                check("cmp_last", bus.mac_last, (t == s - 1) ? 1 : 0);
                check("cmp_psum_valid", bus.psum_valid, 0);
                check("cmp_wr_en", bus.spad_wr_en, 0);
                @(posedge clk); cyc++;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            expected = 0;
            for (int k = 0; k < s; k++) expected += int'(job_data[k]) * int'(job_data[s + o + k]);
            for (int k = 0; k <= stall; k++) begin
                bus.psum_ready = (k == stall);
                #1;
                check("out_psum_valid", bus.psum_valid, 1);
                check("out_mac_en", bus.mac_en, 0);
                check("out_rd1", bus.spad_rd_addr_1, 0);
                check("out_rd2", bus.spad_rd_addr_2, 0);
                check("out_done_early", bus.done, 0);
                check("out_psum", acc, expected);
                @(posedge clk); cyc++;
                @(negedge clk);
            end
            bus.psum_ready = 1'b0;
        end
        #1;
        check("done_pulse", bus.done, 1);
        check("done_cfg_ready", bus.cfg_ready, 1);
        check("job_writes", wr_count - wr0, s + w);
        if (gap_mode == 0 && stall == 0) check("job_cycles", cyc, 1 + s + w + (w - s + 1) * (s + 1));
        @(posedge clk); @(negedge clk); #1;
        check("done_once", bus.done, 0);
    endtask

    task automatic load_t1_row();
        logic [7:0] row [8];
        row = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        for (int i = 0; i < 16; i++) job_data[i] = (i < 8) ? row[i] : 8'd0;
    endtask

    task automatic load_random_row();
        for (int i = 0; i < 16; i++) job_data[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_filt_len = '0; bus.cfg_ifmap_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.psum_ready = 1'b0;
        #12;
        check("rst_state_cfg_ready", bus.cfg_ready, 1);
        check("rst_state_in_ready", bus.in_ready, 0);
        check("rst_state_wr_en", bus.spad_wr_en, 0);
        check("rst_state_mac_en", bus.mac_en, 0);
        check("rst_state_psum_valid", bus.psum_valid, 0);
        check("rst_state_done", bus.done, 0);
        check("rst_state_cfg_err", bus.cfg_err, 0);
        @(negedge clk);
        rst = 1'b0;

        load_t1_row();
        run_job(3, 5, 0, 0, 0);
        run_job(3, 5, 1, 5, 0);

        run_job(0, 4, 0, 0, 0);
        run_job(5, 3, 0, 0, 0);
        run_job(10, 8, 0, 0, 0);

        load_random_row();
        run_job(8, 8, 0, 0, 0);
        run_job(1, 1, 0, 0, 0);

        load_t1_row();
        run_job(3, 5, 0, 0, 2);
        run_job(3, 5, 0, 0, 0);

        for (int j = 0; j < 25; j++) begin
            load_random_row();
            run_job($urandom_range(0, 9), $urandom_range(0, 12), 2, $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
